// File: rtl/impact_macro_seq.sv
// IMPACT macro access sequencer: byte-wide pad bus to N_PROJ SRAM/IMC macros.
// Ports:
//   clk, rst (async, active-low)
//   Data_In/Byte_Select/Data_In_Enable : staging word byte loader
//   Proj_Select, WriteEnable, ReadEnable, Byte_Mode_Enable, Trunc_Enable : command
//   Busy, Data_Out, Out_Valid : status / readback
//   Mac_PreCharge/WL_En/WE/RE, Mac_Din, Mac_Dout : macro side
module impact_macro_seq #(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int N_PROJ    = 4,
    parameter int PRE_CYC   = 2,
    parameter int WL_CYC    = 1,
    parameter int SENSE_CYC = 2,
    localparam int NB   = WORD_W / BYTE_W,
    localparam int BS_W = (NB > 1) ? $clog2(NB) : 1,
    localparam int PS_W = $clog2(N_PROJ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        Data_In,
    input  logic [BS_W-1:0]          Byte_Select,
    input  logic [PS_W-1:0]          Proj_Select,
    input  logic                     Data_In_Enable,
    input  logic                     WriteEnable,
    input  logic                     ReadEnable,
    input  logic                     Byte_Mode_Enable,
    input  logic                     Trunc_Enable,
    output logic                     Busy,
    output logic [BYTE_W-1:0]        Data_Out,
    output logic                     Out_Valid,
    output logic [N_PROJ-1:0]        Mac_PreCharge,
    output logic [N_PROJ-1:0]        Mac_WL_En,
    output logic [N_PROJ-1:0]        Mac_WE,
    output logic [N_PROJ-1:0]        Mac_RE,
    output logic [WORD_W-1:0]        Mac_Din,
    input  logic [N_PROJ*WORD_W-1:0] Mac_Dout
);

    localparam int MAXC0 = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int MAXC  = (MAXC0 > SENSE_CYC) ? MAXC0 : SENSE_CYC;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0]   PRE_LAST = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0]   WL_LAST  = CW'(WL_CYC - 1);
    localparam logic [CW-1:0]   SNS_LAST = CW'(SENSE_CYC - 1);
    localparam logic [BS_W-1:0] NB_LAST  = BS_W'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WL,
        S_SENSE,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PS_W-1:0]     proj_q, proj_d;
    logic                rd_q, rd_d;
    logic [WORD_W-1:0]   stage_q, stage_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   res_q, res_d;
    logic [BYTE_W-1:0]   dout_q, dout_d;
    logic                oval_q, oval_d;
    logic [BS_W-1:0]     lane_q, lane_d;
    logic                bmode_q, bmode_d;
    logic                wep_q, wep_d;
    logic                rep_q, rep_d;

    logic                we_edge, re_edge;
    logic [N_PROJ-1:0]   sel_oh;
    logic [WORD_W-1:0]   mac_word;

    function automatic logic [BYTE_W-1:0] lane_of(
        input logic [WORD_W-1:0] w,
        input logic [BS_W-1:0]   i
    );
        lane_of = w[i*BYTE_W +: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] trunc_word(
        input logic [WORD_W-1:0] w,
        input logic              en,
        input logic [BS_W-1:0]   sel
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int l = 0; l < NB; l++) begin
            if (en && (l > int'(sel))) r[l*BYTE_W +: BYTE_W] = '0;
        end
        trunc_word = r;
    endfunction

    assign we_edge  = WriteEnable & ~wep_q;
    assign re_edge  = ReadEnable & ~rep_q;
    assign sel_oh   = N_PROJ'(1) << proj_q;
    assign mac_word = Mac_Dout[proj_q*WORD_W +: WORD_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            proj_q  <= '0;
            rd_q    <= 1'b0;
            stage_q <= '0;
            word_q  <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            oval_q  <= 1'b0;
            lane_q  <= '0;
            bmode_q <= 1'b0;
            wep_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            proj_q  <= proj_d;
            rd_q    <= rd_d;
            stage_q <= stage_d;
            word_q  <= word_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
            lane_q  <= lane_d;
            bmode_q <= bmode_d;
            wep_q   <= wep_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        proj_d  = proj_q;
        rd_d    = rd_q;
        stage_d = stage_q;
        word_d  = word_q;
        res_d   = res_q;
        dout_d  = dout_q;
        oval_d  = oval_q;
        lane_d  = lane_q;
        bmode_d = bmode_q;
        wep_d   = WriteEnable;
        rep_d   = ReadEnable;

        if (Data_In_Enable) stage_d[Byte_Select*BYTE_W +: BYTE_W] = Data_In;

        // After a byte-mode read the output keeps following Byte_Select
        // over the held result until another read is accepted.
        if (bmode_q) dout_d = lane_of(res_q, Byte_Select);

        Mac_PreCharge = '0;
        Mac_WL_En     = '0;
        Mac_WE        = '0;
        Mac_RE        = '0;

        case (state_q)
            S_IDLE: begin
                // Accept uses the staging word as it stood before this
                // cycle's byte load.
                if (we_edge || re_edge) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    proj_d  = Proj_Select;
                    rd_d    = ~we_edge;
                    word_d  = trunc_word(stage_q, Trunc_Enable, Byte_Select);
                    if (!we_edge) bmode_d = 1'b0;
                end
            end
            S_PRE: begin
                Mac_PreCharge = sel_oh;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_WL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WL: begin
                Mac_WL_En = sel_oh;
                if (!rd_q) Mac_WE = sel_oh;
                if (cnt_q == WL_LAST) begin
                    state_d = rd_q ? S_SENSE : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SENSE: begin
                Mac_RE = sel_oh;
                if (cnt_q == SNS_LAST) begin
                    // Preload the first output byte so Out_Valid rises
                    // on the cycle right after sensing.
                    state_d = S_OUT;
                    cnt_d   = '0;
                    res_d   = mac_word;
                    oval_d  = 1'b1;
                    lane_d  = '0;
                    dout_d  = lane_of(mac_word,
                                      Byte_Mode_Enable ? Byte_Select : '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (Byte_Mode_Enable) begin
                    state_d = S_IDLE;
                    oval_d  = 1'b0;
                    bmode_d = 1'b1;
                    dout_d  = lane_of(res_q, Byte_Select);
                end else if (lane_q == NB_LAST) begin
                    state_d = S_IDLE;
                    oval_d  = 1'b0;
                end else begin
                    lane_d = lane_q + 1'b1;
                    dout_d = lane_of(res_q, lane_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy      = (state_q != S_IDLE);
    assign Data_Out  = dout_q;
    assign Out_Valid = oval_q;
    assign Mac_Din   = word_q;

endmodule

// File: tb/tb_impact_macro_seq.sv
// Scoreboard bench for impact_macro_seq with default parameters.
// Expected macro phases, readback bytes and Busy windows are queued per command.
module tb_impact_macro_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  Data_In;
    logic [1:0]  Byte_Select;
    logic [1:0]  Proj_Select;
    logic        Data_In_Enable;
    logic        WriteEnable;
    logic        ReadEnable;
    logic        Byte_Mode_Enable;
    logic        Trunc_Enable;
    logic        Busy;
    logic [7:0]  Data_Out;
    logic        Out_Valid;
    logic [3:0]  Mac_PreCharge;
    logic [3:0]  Mac_WL_En;
    logic [3:0]  Mac_WE;
    logic [3:0]  Mac_RE;
    logic [31:0] Mac_Din;
    logic [127:0] Mac_Dout;
    logic [31:0] mdout [4];

    assign Mac_Dout = {mdout[3], mdout[2], mdout[1], mdout[0]};

    impact_macro_seq dut (
        .clk              (clk),
        .rst              (rst),
        .Data_In          (Data_In),
        .Byte_Select      (Byte_Select),
        .Proj_Select      (Proj_Select),
        .Data_In_Enable   (Data_In_Enable),
        .WriteEnable      (WriteEnable),
        .ReadEnable       (ReadEnable),
        .Byte_Mode_Enable (Byte_Mode_Enable),
        .Trunc_Enable     (Trunc_Enable),
        .Busy             (Busy),
        .Data_Out         (Data_Out),
        .Out_Valid        (Out_Valid),
        .Mac_PreCharge    (Mac_PreCharge),
        .Mac_WL_En        (Mac_WL_En),
        .Mac_WE           (Mac_WE),
        .Mac_RE           (Mac_RE),
        .Mac_Din          (Mac_Din),
        .Mac_Dout         (Mac_Dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  pre;
        logic [3:0]  wl;
        logic [3:0]  we;
        logic [3:0]  re;
        logic        din_chk;
        logic [31:0] din;
    } mac_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } out_t;

    mac_t mq[$];
    out_t oq[$];

    int cyc     = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int checks  = 0;
    int errors  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void push_mac(int c, logic [3:0] pre, logic [3:0] wl,
                                     logic [3:0] we, logic [3:0] re,
                                     logic dc, logic [31:0] din);
        mac_t e;
        e.cyc = c; e.pre = pre; e.wl = wl; e.we = we; e.re = re;
        e.din_chk = dc; e.din = din;
        mq.push_back(e);
    endfunction

    function automatic void push_out(int c, logic [7:0] d);
        out_t e;
        e.cyc = c; e.d = d;
        oq.push_back(e);
    endfunction

    // Command edge sampled in cycle t: PRE t+1..t+2, WL t+3, SENSE t+4..t+5,
    // readback from t+6.
    function automatic void push_seq(int t, int p, bit rd, bit bm, int bsel,
                                     logic [31:0] din);
        logic [3:0]  oh;
        logic [31:0] w;
        oh = 4'b0001 << p;
        w  = mdout[p];
        busy_lo = t + 1;
        push_mac(t + 1, oh, 4'b0, 4'b0, 4'b0, 1'b0, 32'h0);
        push_mac(t + 2, oh, 4'b0, 4'b0, 4'b0, 1'b0, 32'h0);
        push_mac(t + 3, 4'b0, oh, rd ? 4'b0 : oh, 4'b0, !rd, din);
        if (!rd) begin
            busy_hi = t + 3;
        end else begin
            push_mac(t + 4, 4'b0, 4'b0, 4'b0, oh, 1'b0, 32'h0);
            push_mac(t + 5, 4'b0, 4'b0, 4'b0, oh, 1'b0, 32'h0);
            if (bm) begin
                push_out(t + 6, w[bsel*8 +: 8]);
                busy_hi = t + 6;
            end else begin
                for (int l = 0; l < 4; l++) push_out(t + 6 + l, w[l*8 +: 8]);
                busy_hi = t + 9;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", 64'(Busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
            while (mq.size() > 0 && mq[0].cyc < cyc) begin
                chk("mac_missing", 64'(cyc), 64'(mq[0].cyc));
                void'(mq.pop_front());
            end
            while (oq.size() > 0 && oq[0].cyc < cyc) begin
                chk("out_missing", 64'(cyc), 64'(oq[0].cyc));
                void'(oq.pop_front());
            end
            if (|{Mac_PreCharge, Mac_WL_En, Mac_WE, Mac_RE}) begin
                if (mq.size() == 0) begin
                    chk("mac_unexpected",
                        64'({Mac_PreCharge, Mac_WL_En, Mac_WE, Mac_RE}), 64'h0);
                end else begin
                    mac_t e;
                    e = mq.pop_front();
                    chk("mac_ctrl",
                        {16'(cyc), Mac_PreCharge, Mac_WL_En, Mac_WE, Mac_RE},
                        {16'(e.cyc), e.pre, e.wl, e.we, e.re});
                    if (e.din_chk) chk("mac_din", 64'(Mac_Din), 64'(e.din));
                end
            end
            if (Out_Valid) begin
                if (oq.size() == 0) begin
                    chk("out_unexpected", 64'(Data_Out), 64'hx);
                end else begin
                    out_t e;
                    e = oq.pop_front();
                    chk("data_out", {16'(cyc), 8'(Data_Out)},
                        {16'(e.cyc), 8'(e.d)});
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst = 1'b0;
        Data_In = '0; Byte_Select = '0; Proj_Select = '0;
        Data_In_Enable = 1'b0; WriteEnable = 1'b0; ReadEnable = 1'b0;
        Byte_Mode_Enable = 1'b0; Trunc_Enable = 1'b0;
        mdout[0] = 32'hA0A1A2A3;
        mdout[1] = 32'hDEADBEEF;
        mdout[2] = 32'h12345678;
        mdout[3] = 32'hCAFEF00D;
        tick(2);
        chk("rst_outputs",
            {Busy, Out_Valid, Data_Out, Mac_PreCharge, Mac_WL_En, Mac_WE, Mac_RE},
            '0);
        chk("rst_din", 64'(Mac_Din), 64'h0);
        rst = 1'b1;
        tick(2);

        // 1: load lanes, write proj 2 with WriteEnable held high
        for (int l = 0; l < 4; l++) begin
            Byte_Select = 2'(l);
            Data_In = 8'(8'h11 * (l + 1));
            Data_In_Enable = 1'b1;
            tick(1);
        end
        Data_In_Enable = 1'b0;
        Byte_Select = 2'd0;
        Proj_Select = 2'd2;
        WriteEnable = 1'b1;
        t = cyc;
        push_seq(t, 2, 0, 0, 0, 32'h44332211);
        tick(6);
        WriteEnable = 1'b0;
        tick(3);

        // 2: serial read proj 1
        Proj_Select = 2'd1;
        ReadEnable = 1'b1;
        t = cyc;
        push_seq(t, 1, 1, 0, 0, 32'h0);
        tick(1);
        ReadEnable = 1'b0;
        tick(12);

        // 3: byte-mode read, then retarget Byte_Select
        Byte_Mode_Enable = 1'b1;
        Byte_Select = 2'd2;
        ReadEnable = 1'b1;
        t = cyc;
        push_seq(t, 1, 1, 1, 2, 32'h0);
        tick(1);
        ReadEnable = 1'b0;
        tick(6);
        chk("byte_hold", 64'(Data_Out), 64'hAD);
        Byte_Select = 2'd3;
        tick(1);
        chk("byte_track", 64'(Data_Out), 64'hDE);
        tick(2);

        // 4: truncated write
        Trunc_Enable = 1'b1;
        Byte_Select = 2'd1;
        Proj_Select = 2'd0;
        WriteEnable = 1'b1;
        t = cyc;
        push_seq(t, 0, 0, 0, 0, 32'h00002211);
        tick(1);
        WriteEnable = 1'b0;
        Trunc_Enable = 1'b0;
        tick(5);

        // 5: simultaneous edges, then a read edge while busy
        Byte_Select = 2'd0;
        Byte_Mode_Enable = 1'b0;
        Proj_Select = 2'd3;
        WriteEnable = 1'b1;
        ReadEnable = 1'b1;
        t = cyc;
        push_seq(t, 3, 0, 0, 0, 32'h44332211);
        tick(1);
        WriteEnable = 1'b0;
        ReadEnable = 1'b0;
        tick(1);
        ReadEnable = 1'b1;
        tick(1);
        ReadEnable = 1'b0;
        tick(5);

        // 6: reset during WL of a write, then a fresh read
        Proj_Select = 2'd0;
        WriteEnable = 1'b1;
        t = cyc;
        busy_lo = t + 1;
        busy_hi = t + 2;
        push_mac(t + 1, 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 32'h0);
        push_mac(t + 2, 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 32'h0);
        tick(1);
        WriteEnable = 1'b0;
        tick(2);
        chk("wl_before_rst", {Mac_WL_En, Mac_WE}, {4'b0001, 4'b0001});
        #1 rst = 1'b0;
        #1;
        chk("async_rst",
            {Busy, Mac_PreCharge, Mac_WL_En, Mac_WE, Mac_RE}, '0);
        tick(2);
        rst = 1'b1;
        tick(2);
        Proj_Select = 2'd2;
        ReadEnable = 1'b1;
        t = cyc;
        push_seq(t, 2, 1, 0, 0, 32'h0);
        tick(1);
        ReadEnable = 1'b0;
        tick(12);

        chk("mac_queue_empty", 64'(mq.size()), 64'h0);
        chk("out_queue_empty", 64'(oq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
